// File: rtl/i2s_pkg.sv
// Shared types for the multi-line I2S receiver: capture mode encoding,
// slot channel codes and the mode decode/enable helpers.
package i2s_pkg;

  typedef enum logic [1:0] {
    I2S_STEREO = 2'd0,
    I2S_LEFT   = 2'd1,
    I2S_RIGHT  = 2'd2
  } i2s_mode_e;

  localparam logic CHAN_LEFT  = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;

  function automatic i2s_mode_e decode_mode(input logic [1:0] raw);
    i2s_mode_e m;
    case (raw)
      2'd1:    m = I2S_LEFT;
      2'd2:    m = I2S_RIGHT;
      default: m = I2S_STEREO;
    endcase
    return m;
  endfunction

  function automatic logic chan_enabled(input i2s_mode_e m, input logic chan);
    logic en;
    case (m)
      I2S_LEFT:  en = (chan == CHAN_LEFT);
      I2S_RIGHT: en = (chan == CHAN_RIGHT);
      default:   en = 1'b1;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/i2s_sample_fifo.sv
// Small synchronous FIFO with a registered valid/ready read head.
// A push on a full FIFO is accepted only when the head is popped in the same cycle.
module i2s_sample_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_valid_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic             full_o,
  output logic             pop_valid_o,
  input  logic             pop_ready_i,
  output logic [WIDTH-1:0] pop_data_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             full_s, pop_s, push_s;

  // Head register looks ahead through the next-state storage so a word
  // written into an empty FIFO appears on the output one cycle later.
  always_comb begin
    full_s = (count_q == CW'(DEPTH));
    pop_s  = valid_q && pop_ready_i;
    push_s = push_valid_i && (!full_s || pop_s);
    mem_d  = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d        = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);
    valid_d = (count_d != CW'(0));
    if (valid_d) begin
      data_d = mem_d[rd_ptr_d];
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
      valid_q  <= 1'b0;
      data_q   <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

  assign full_o      = full_s;
  assign pop_valid_o = valid_q;
  assign pop_data_o  = data_q;

endmodule

// File: rtl/i2s_rx_multi.sv
// Multi-line I2S clock master and receiver: generates SCK/WS from audio_clk,
// deserialises NUM_LINES mic lines and queues one word per enabled slot.
module i2s_rx_multi
  import i2s_pkg::*;
#(
  parameter int SCK_DIV      = 32,
  parameter int SLOT_BITS    = 32,
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_LINES    = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                              audio_clk,
  input  logic                              rst_in,
  input  logic                              enable_in,
  input  logic [1:0]                        mode_in,
  input  logic [NUM_LINES-1:0]              mic_data_in,
  output logic                              i2s_clk_out,
  output logic                              lrcl_clk_out,
  output logic                              sample_valid_out,
  input  logic                              sample_ready_in,
  output logic                              sample_chan_out,
  output logic [NUM_LINES*SAMPLE_WIDTH-1:0] sample_data_out,
  output logic                              overrun_out,
  input  logic                              clear_overrun_in
);

  localparam int CW = $clog2(SCK_DIV);
  localparam int BW = $clog2(SLOT_BITS);
  localparam int DW = NUM_LINES * SAMPLE_WIDTH;
  localparam int FW = DW + 1;

  localparam logic [CW-1:0] SCK_LAST   = CW'(SCK_DIV - 1);
  localparam logic [CW-1:0] SCK_HALF   = CW'(SCK_DIV / 2);
  localparam logic [CW-1:0] SCK_SAMPLE = CW'((3 * SCK_DIV) / 4);
  localparam logic [BW-1:0] BIT_LAST   = BW'(SLOT_BITS - 1);
  localparam logic [BW-1:0] BIT_FIRST  = BW'(1);
  localparam logic [BW-1:0] BIT_FINAL  = BW'(SAMPLE_WIDTH);

  logic [CW-1:0]           sck_cnt_q, sck_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    sck_q, sck_d;
  logic                    ws_q, ws_d;
  logic                    armed_q, armed_d;
  i2s_mode_e               mode_q, mode_d;
  logic [NUM_LINES-1:0]    meta_q, meta_d;
  logic [NUM_LINES-1:0]    sync_q, sync_d;
  logic [SAMPLE_WIDTH-1:0] shift_q [NUM_LINES];
  logic [SAMPLE_WIDTH-1:0] shift_d [NUM_LINES];
  logic                    overrun_q, overrun_d;

  logic          fall_s, slot_end_s, ws_fall_s, sample_s, capture_s;
  logic          push_s, pop_s, drop_s;
  logic [FW-1:0] push_data_s;
  logic          fifo_full_s, fifo_valid_s;
  logic [FW-1:0] fifo_data_s;

  // Clock generation and slot framing; WS toggles on the SCK fall that wraps bit_cnt.
  always_comb begin
    fall_s     = enable_in && (sck_cnt_q == SCK_LAST);
    slot_end_s = fall_s && (bit_cnt_q == BIT_LAST);
    ws_fall_s  = slot_end_s && ws_q;
    sample_s   = enable_in && (sck_cnt_q == SCK_SAMPLE);
    meta_d     = mic_data_in;
    sync_d     = meta_q;
    if (!enable_in) begin
      sck_cnt_d = CW'(0);
      bit_cnt_d = BW'(0);
      ws_d      = 1'b1;
      armed_d   = 1'b0;
    end else begin
      if (fall_s) begin
        sck_cnt_d = CW'(0);
        bit_cnt_d = slot_end_s ? BW'(0) : bit_cnt_q + BW'(1);
      end else begin
        sck_cnt_d = sck_cnt_q + CW'(1);
        bit_cnt_d = bit_cnt_q;
      end
      ws_d    = slot_end_s ? ~ws_q : ws_q;
      armed_d = armed_q || ws_fall_s;
    end
    sck_d  = (sck_cnt_d >= SCK_HALF);
    mode_d = ws_fall_s ? decode_mode(mode_in) : mode_q;
  end

  // Slot bit 0 is the I2S one-bit delay, so capture covers bits 1..SAMPLE_WIDTH.
  always_comb begin
    capture_s   = sample_s && (bit_cnt_q >= BIT_FIRST) && (bit_cnt_q <= BIT_FINAL);
    push_s      = sample_s && armed_q && (bit_cnt_q == BIT_FINAL) && chan_enabled(mode_q, ws_q);
    push_data_s = {FW{1'b0}};
    for (int k = 0; k < NUM_LINES; k++) begin
      if (capture_s) begin
        shift_d[k] = (shift_q[k] << 1) | SAMPLE_WIDTH'(sync_q[k]);
      end else begin
        shift_d[k] = shift_q[k];
      end
      push_data_s[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = shift_d[k];
    end
    push_data_s[FW-1] = ws_q;
    pop_s  = fifo_valid_s && sample_ready_in;
    drop_s = push_s && fifo_full_s && !pop_s;
    if (drop_s) begin
      overrun_d = 1'b1;
    end else if (clear_overrun_in) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  always_ff @(posedge audio_clk or negedge rst_in) begin
    if (!rst_in) begin
      sck_cnt_q <= CW'(0);
      bit_cnt_q <= BW'(0);
      sck_q     <= 1'b0;
      ws_q      <= 1'b1;
      armed_q   <= 1'b0;
      mode_q    <= I2S_STEREO;
      meta_q    <= {NUM_LINES{1'b0}};
      sync_q    <= {NUM_LINES{1'b0}};
      overrun_q <= 1'b0;
      for (int k = 0; k < NUM_LINES; k++) begin
        shift_q[k] <= {SAMPLE_WIDTH{1'b0}};
      end
    end else begin
      sck_cnt_q <= sck_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sck_q     <= sck_d;
      ws_q      <= ws_d;
      armed_q   <= armed_d;
      mode_q    <= mode_d;
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      overrun_q <= overrun_d;
      for (int k = 0; k < NUM_LINES; k++) begin
        shift_q[k] <= shift_d[k];
      end
    end
  end

  i2s_sample_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (audio_clk),
    .rst_n        (rst_in),
    .push_valid_i (push_s),
    .push_data_i  (push_data_s),
    .full_o       (fifo_full_s),
    .pop_valid_o  (fifo_valid_s),
    .pop_ready_i  (sample_ready_in),
    .pop_data_o   (fifo_data_s)
  );

  assign i2s_clk_out      = sck_q;
  assign lrcl_clk_out     = ws_q;
  assign sample_valid_out = fifo_valid_s;
  assign sample_chan_out  = fifo_data_s[FW-1];
  assign sample_data_out  = fifo_data_s[DW-1:0];
  assign overrun_out      = overrun_q;

endmodule
